// File: rtl/alu_result_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : Writeback-side stage behind the 16-bit ALU. Captures each ALU
//             result into a 2-entry elastic buffer and hands it to the
//             register-file write port over valid/ready. Also owns the
//             architectural flags: carry (fed back to ALU c_in) and,
//             optionally, zero and negative.
//  Options  : `define ALU_ZN_FLAGS_EN to build the zero_flag / neg_flag
//             ports and registers. Without it only carry_flag is kept.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             in_valid/in_ready   - ALU result handshake
//             in_data, in_c       - ALU result and carry-out
//             in_carry_we         - result updates the carry flag
//             in_rd, in_wen       - destination register / write enable
//             out_valid/out_ready - register-file write handshake
//             out_data, out_rd,
//             out_wen             - head entry of the buffer
//             flags_clr           - synchronous clear of all flags
//             zero_flag, neg_flag - (ALU_ZN_FLAGS_EN only)
//             carry_flag          - to ALU c_in
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_c,
    input  logic              in_carry_we,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    input  logic              flags_clr,
`ifdef ALU_ZN_FLAGS_EN
    output logic              zero_flag,
    output logic              neg_flag,
`endif
    output logic              carry_flag
);

    localparam logic [1:0] c_count_full = 2'd2;
    localparam logic [1:0] c_count_zero = 2'd0;

    logic [DATA_W-1:0] r_mem_data [2];
    logic [RD_W-1:0]   r_mem_rd   [2];
    logic              r_mem_wen  [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_carry;

    logic              w_push;
    logic              w_pop;

    // Both handshake outputs come straight from the count register, so
    // in_ready never depends combinationally on out_ready.
    assign in_ready  = (r_count != c_count_full);
    assign out_valid = (r_count != c_count_zero);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data   = r_mem_data[r_rd_ptr];
    assign out_rd     = r_mem_rd[r_rd_ptr];
    assign out_wen    = r_mem_wen[r_rd_ptr];
    assign carry_flag = r_carry;

    // Storage is reset too so the head reads as all-zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_rd[0]   <= '0;
            r_mem_rd[1]   <= '0;
            r_mem_wen[0]  <= 1'b0;
            r_mem_wen[1]  <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= in_data;
                r_mem_rd[r_wr_ptr]   <= in_rd;
                r_mem_wen[r_wr_ptr]  <= in_wen;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // A simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over a flag update from a push in the same cycle; the
    // data entry itself is still captured by the buffer above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (flags_clr) begin
            r_carry <= 1'b0;
        end else if (w_push && in_carry_we) begin
            r_carry <= in_c;
        end
    end

`ifdef ALU_ZN_FLAGS_EN
    logic r_zero;
    logic r_neg;

    assign zero_flag = r_zero;
    assign neg_flag  = r_neg;

    // Every accepted result updates Z/N, including ones with in_wen = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (flags_clr) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_push) begin
            r_zero <= (in_data == '0);
            r_neg  <= in_data[DATA_W-1];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Directed self-checking bench for alu_result_stage. Zero/neg
//             flag checks are included when ALU_ZN_FLAGS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_c;
    logic              in_carry_we;
    logic [RD_W-1:0]   in_rd;
    logic              in_wen;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_wen;
    logic              flags_clr;
    logic              carry_flag;
`ifdef ALU_ZN_FLAGS_EN
    logic              zero_flag;
    logic              neg_flag;
`endif

    int checks = 0;
    int errors = 0;

    alu_result_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_c        (in_c),
        .in_carry_we (in_carry_we),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .flags_clr   (flags_clr),
`ifdef ALU_ZN_FLAGS_EN
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
`endif
        .carry_flag  (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic c,
                         input logic cwe, input logic [RD_W-1:0] rd, input logic wen,
                         input logic ordy, input logic clr);
        in_valid    = v;
        in_data     = d;
        in_c        = c;
        in_carry_we = cwe;
        in_rd       = rd;
        in_wen      = wen;
        out_ready   = ordy;
        flags_clr   = clr;
    endtask

    // Advance one edge, then sample 1 ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_d;
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset state
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_out_data",  32'(out_data),   32'h0);
        chk("rst_out_rd",    32'(out_rd),     32'h0);
        chk("rst_out_wen",   32'(out_wen),    32'd0);
        chk("rst_carry",     32'(carry_flag), 32'd0);
`ifdef ALU_ZN_FLAGS_EN
        chk("rst_zero",      32'(zero_flag),  32'd0);
        chk("rst_neg",       32'(neg_flag),   32'd0);
`endif
        rst_n = 1'b1;

        // Carry update, then carry hold on a non-carry op with wen = 0
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("cu_carry",     32'(carry_flag), 32'd1);
        chk("cu_out_valid", 32'(out_valid),  32'd1);
        chk("cu_out_data",  32'(out_data),   32'h0000);
        chk("cu_out_rd",    32'(out_rd),     32'h1);
        chk("cu_out_wen",   32'(out_wen),    32'd1);
`ifdef ALU_ZN_FLAGS_EN
        chk("cu_zero",      32'(zero_flag),  32'd1);
        chk("cu_neg",       32'(neg_flag),   32'd0);
`endif
        drive(1'b1, 16'h8001, 1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ch_carry",     32'(carry_flag), 32'd1);
        chk("ch_out_data",  32'(out_data),   32'h8001);
        chk("ch_out_rd",    32'(out_rd),     32'h2);
        chk("ch_out_wen",   32'(out_wen),    32'd0);
        chk("ch_in_ready",  32'(in_ready),   32'd1);
`ifdef ALU_ZN_FLAGS_EN
        chk("ch_zero",      32'(zero_flag),  32'd0);
        chk("ch_neg",       32'(neg_flag),   32'd1);
`endif
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ch_drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        chk("bp_head_1",  32'(out_data), 32'hAAAA);
        drive(1'b1, 16'hBBBB, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_ready_2", 32'(in_ready), 32'd0);
        chk("bp_head_2",  32'(out_data), 32'hAAAA);
        drive(1'b1, 16'hCCCC, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_ready_3", 32'(in_ready), 32'd0);
        chk("bp_head_3",  32'(out_data), 32'hAAAA);
        chk("bp_rd_3",    32'(out_rd),   32'h3);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("bp_ready_no_comb", 32'(in_ready), 32'd0);
        tick();
        chk("bp_ready_pop",  32'(in_ready),  32'd1);
        chk("bp_head_b",     32'(out_data),  32'hBBBB);
        chk("bp_rd_b",       32'(out_rd),    32'h4);
        chk("bp_carry_hold", 32'(carry_flag), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: one result per cycle, head always the latest push
        for (int i = 0; i < 16; i++) begin
            exp_d = 16'h1000 + 16'(i * 16'h0111);
            drive(1'b1, exp_d, 1'b0, 1'b0, 4'(i), i[0], 1'b1, 1'b0);
            tick();
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_ready", 32'(in_ready),  32'd1);
            chk("st_data",  32'(out_data),  32'(exp_d));
            chk("st_rd",    32'(out_rd),    32'(i));
            chk("st_wen",   32'(out_wen),   32'(i[0]));
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("st_drain", 32'(out_valid), 32'd0);

        // Clear priority over a simultaneous flag update
        drive(1'b1, 16'h0001, 1'b1, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0);
        tick();
        chk("cp_pre_carry", 32'(carry_flag), 32'd1);
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
        tick();
        chk("cp_carry",   32'(carry_flag), 32'd0);
        chk("cp_valid",   32'(out_valid),  32'd1);
        chk("cp_data",    32'(out_data),   32'h0000);
        chk("cp_rd",      32'(out_rd),     32'h5);
`ifdef ALU_ZN_FLAGS_EN
        chk("cp_zero",    32'(zero_flag),  32'd0);
        chk("cp_neg",     32'(neg_flag),   32'd0);
`endif
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("cp_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset with two entries held
        drive(1'b1, 16'h1111, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ar_pre_ready", 32'(in_ready),   32'd0);
        chk("ar_pre_carry", 32'(carry_flag), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid),  32'd0);
        chk("ar_ready", 32'(in_ready),   32'd1);
        chk("ar_carry", 32'(carry_flag), 32'd0);
        chk("ar_data",  32'(out_data),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ar_first_valid", 32'(out_valid), 32'd1);
        chk("ar_first_data",  32'(out_data),  32'h1234);
        chk("ar_first_rd",    32'(out_rd),    32'h9);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ar_drain", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
# alu_result_stage

Writeback-side stage directly downstream of the 16-bit ALU. It captures each ALU result and carry-out into a 2-entry elastic buffer and presents them to the register-file write port through a valid/ready handshake. It also owns the architectural flag registers: carry, which feeds back into the ALU carry-in, plus zero and negative.

## Interface
Parameters:
- DATA_W, 16, result width; must match the ALU datapath.
- RD_W, 4, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; high when fewer than 2 entries are held.
- in_data  in  DATA_W  ALU `out`.
- in_c  in  1  ALU `c_out`.
- in_carry_we  in  1  result updates the carry flag (add/sub ops only).
- in_rd  in  RD_W  destination register.
- in_wen  in  1  result is written to the register file.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register-file port accepts the head entry.
- out_data  out  DATA_W  head result.
- out_rd  out  RD_W  head destination.
- out_wen  out  1  head write enable; qualified by out_valid.
- flags_clr  in  1  synchronous clear of all flags.
- carry_flag  out  1  to ALU `c_in`.
- zero_flag  out  1  present only with ALU_ZN_FLAGS_EN.
- neg_flag  out  1  present only with ALU_ZN_FLAGS_EN.

## Operation
- **Buffer.** 2-entry FIFO holding {data, rd, wen}: 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- **Push and pop.** push = in_valid & in_ready. pop = out_valid & out_ready.
- **in_ready.** in_ready = (count != 2). It is registered-derived and has no combinational path from out_ready.
- **Count update.** count += push − pop.
- **Push and pop in the same cycle.** Allowed when count = 1 and count stays 1. At count = 0, a push with no valid head cannot pop in the same cycle.
- **Output.** out_valid = (count != 0). out_* are driven from the entry at the read pointer.
- **Head stability.** Once out_valid is high, out_data/out_rd/out_wen hold stable until pop.
- **Carry flag.** On push with in_carry_we = 1, carry_flag ← in_c. Otherwise carry_flag holds.
- **Zero and negative flags (ALU_ZN_FLAGS_EN).** On every push, zero_flag ← (in_data == 0) and neg_flag ← in_data[DATA_W−1].
- **Flag clear.** flags_clr = 1 clears every flag the next edge. It takes priority over a flag update from a simultaneous push. The data entry is still pushed.
- **Entries without a write.** Entries with in_wen = 0 (e.g. compare-style ops) still occupy a slot and still update flags.
- **Reset.** Asynchronous reset clears the pointers, count and all flags. Any in-flight entries are discarded.

## Timing
- **Reset values.** in_ready = 1, out_valid = 0, out_data = 0, out_rd = 0, out_wen = 0, carry_flag = 0, zero_flag = 0, neg_flag = 0.
- **Latency.** A result pushed at edge N is at the head with out_valid = 1 after edge N.
- **Flag visibility.** Flags update at the push edge. A dependent ALU op in cycle N+1 sees the new carry_flag.
- **Throughput.** 1 entry/cycle when out_ready is held high.
- **Back-pressure.** in_ready falls the cycle after the second unpopped push. It rises the cycle after a pop from full.
- **Reset mid-operation.** rst_n low forces all outputs to reset values immediately, asynchronously. Release is synchronous to the next clk edge.

## Configuration
- **ALU_ZN_FLAGS_EN defined.** zero_flag/neg_flag ports and registers exist and behave as described in Operation.
- **ALU_ZN_FLAGS_EN undefined.** The ports are absent and only carry_flag is kept. Buffer behaviour is unchanged.

## Test plan
- **Reset.** Assert rst_n = 0 mid-stream with 2 entries held → out_valid = 0, in_ready = 1, carry_flag = 0 immediately. After release, the first push of 0x1234 appears on out_data one cycle later.
- **Carry update and hold.** Push in_data = 0x0000, in_c = 1, in_carry_we = 1 → carry_flag = 1 next cycle and zero_flag = 1. Then push 0x8001 with in_carry_we = 0 → carry_flag stays 1, neg_flag = 1, zero_flag = 0.
- **Back-pressure.** Hold out_ready = 0 and push 0xAAAA, 0xBBBB, 0xCCCC on consecutive cycles → in_ready drops after the second push and 0xCCCC is not accepted. Raise out_ready → the outputs appear in order 0xAAAA then 0xBBBB, and in_ready rises one cycle after the first pop.
- **Streaming.** Push 16 results with in_valid = out_ready = 1 continuously → count stays 1, out_valid stays high, and there is one output per cycle in order with rd/wen matching.
- **Clear priority.** Assert flags_clr together with a push of in_c = 1, in_carry_we = 1, data 0x0000 → next cycle carry_flag = 0 and zero_flag = 0, and the data entry 0x0000 still emerges on out_data.
